feature_framer: RTL and testbench

Front-end feeder for the combinational decision-tree classifiers. Accepts a byte-serial feature stream over a valid/ready handshake, assembles one frame of NUM_FEATURES 8-bit features, and drives them in parallel, held stable, onto the tree's X inputs. After a programmable settle interval it samples the tree's class output and returns it over a second valid/ready handshake. Frame-alignment errors are detected and the stream is resynchronised.

---
 rtl/feature_framer_pkg.sv | 24 ++
 rtl/feature_framer.sv | 134 +++++++++++++
 tb/tb_feature_framer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_framer_pkg.sv
// +-----------------------------------------------------------------------+
// | feature_framer_pkg : shared types and default sizes for feature_framer |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

package feature_framer_pkg;

    localparam int c_num_features  = 5;
    localparam int c_feat_w        = 8;
    localparam int c_class_w       = 1;
    localparam int c_settle_cycles = 2;
    localparam int c_settle_w      = 4;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/feature_framer.sv
// +-----------------------------------------------------------------------+
// | feature_framer : byte-serial feature assembly, hold-and-sample of a    |
// | combinational tree class output, with frame-alignment recovery         |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module feature_framer
    import feature_framer_pkg::*;
#(
    parameter int NUM_FEATURES  = c_num_features,
    parameter int FEAT_W        = c_feat_w,
    parameter int CLASS_W       = c_class_w,
    parameter int SETTLE_CYCLES = c_settle_cycles
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [FEAT_W-1:0]            s_data,
    input  logic                         s_last,
    output logic [NUM_FEATURES*FEAT_W-1:0] feat_o,
    input  logic [CLASS_W-1:0]           class_i,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [CLASS_W-1:0]           m_class,
    output logic                         frame_err
);

    localparam int c_idx_w = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

    state_t                          r_state;
    state_t                          w_next_state;
    logic [c_idx_w-1:0]              r_idx;
    logic [c_settle_w-1:0]           r_cnt;
    logic [NUM_FEATURES*FEAT_W-1:0]  r_feat;
    logic [CLASS_W-1:0]              r_class;
    logic                            r_frame_err;

    logic w_accept;
    logic w_last_idx;
    logic w_collect_wr;
    logic w_settle_done;

    assign w_accept      = s_valid && s_ready;
    assign w_last_idx    = (r_idx == c_idx_w'(NUM_FEATURES - 1));
    assign w_collect_wr  = w_accept && (r_state == ST_COLLECT);
    assign w_settle_done = (r_state == ST_SETTLE) && (r_cnt <= c_settle_w'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_COLLECT: begin
                if (w_accept && w_last_idx) begin
                    w_next_state = s_last ? ST_SETTLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_accept && s_last) begin
                    w_next_state = ST_COLLECT;
                end
            end
            ST_SETTLE: begin
                if (w_settle_done) begin
                    w_next_state = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (m_ready) begin
                    w_next_state = ST_COLLECT;
                end
            end
            default: w_next_state = ST_COLLECT;
        endcase
    end

    // s_ready is gated by rst_n so the stream sees back-pressure for the whole reset.
    always_comb begin
        s_ready = rst_n && ((r_state == ST_COLLECT) || (r_state == ST_DRAIN));
        m_valid = (r_state == ST_RESULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_feat      <= '0;
            r_class     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            // Mismatch between s_last and the final slot is either a short or a long frame.
            r_frame_err <= w_collect_wr && (s_last ^ w_last_idx);

            if (w_collect_wr) begin
                for (int k = 0; k < NUM_FEATURES; k++) begin
                    if (r_idx == c_idx_w'(k)) begin
                        r_feat[k*FEAT_W +: FEAT_W] <= s_data;
                    end
                end
                if (s_last || w_last_idx) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + c_idx_w'(1);
                end
                if (s_last && w_last_idx) begin
                    r_cnt <= c_settle_w'(SETTLE_CYCLES);
                end
            end

            if (r_state == ST_SETTLE) begin
                r_cnt <= r_cnt - c_settle_w'(1);
            end

            if (w_settle_done) begin
                r_class <= class_i;
            end
        end
    end

    assign feat_o    = r_feat;
    assign m_class   = r_class;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_feature_framer.sv
// +-----------------------------------------------------------------------+
// | tb_feature_framer : table, directed and randomized checks of framer    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_feature_framer;

    typedef logic [7:0] frame_t [8];

    typedef struct {
        frame_t      b;
        int          len;
        logic [39:0] feat;
        logic        err;
        logic        cls;
    } vec_t;

    logic        clk;
    logic        rst_n;

    logic        s_valid, s_ready, s_last, m_valid, m_ready, frame_err;
    logic [7:0]  s_data;
    logic [39:0] feat_o;
    logic [0:0]  class_i, m_class;

    logic        s_valid1, s_ready1, s_last1, m_valid1, m_ready1, frame_err1;
    logic [7:0]  s_data1;
    logic [39:0] feat_o1;
    logic [0:0]  class_i1, m_class1;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    logic [39:0] model_feat;

    // Tree stub: class is 1 when either of the top two bits of X0 is set.
    assign class_i  = (feat_o[7:6]  != 2'b00);
    assign class_i1 = (feat_o1[7:6] != 2'b00);

    feature_framer #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .feat_o(feat_o), .class_i(class_i),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .frame_err(frame_err)
    );

    feature_framer #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1), .s_last(s_last1),
        .feat_o(feat_o1), .class_i(class_i1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_class(m_class1),
        .frame_err(frame_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Returns 1ns after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (1) begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 50) begin
                n_checks++;
                n_err++;
                $display("FAIL send_timeout: s_ready stuck at 0, required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Frame-level reference: bytes past the fifth are dropped, short/long frames flag an error.
    task automatic model_frame(input logic [39:0] prev, input frame_t fb, input int len,
                               output logic [39:0] nf, output logic err, output logic cls);
        nf = prev;
        for (int i = 0; i < len && i < 5; i++) nf[i*8 +: 8] = fb[i];
        err = (len != 5);
        cls = (nf[7:0] >= 8'h40);
    endtask

    task automatic run_frame(input frame_t fb, input int len, input logic [39:0] ef,
                             input logic ee, input logic ec, input int hold);
        int err_pos;
        err_pos = (len < 5) ? len - 1 : 4;
        for (int i = 0; i < len; i++) begin
            send_byte(fb[i], (i == len - 1));
            check("frame_err", {63'd0, frame_err}, {63'd0, (ee && (i == err_pos))});
        end
        check("feat_o", {24'd0, feat_o}, {24'd0, ef});
        if (!ee) begin
            @(posedge clk); #1;
            check("m_valid_early", {63'd0, m_valid}, 64'd0);
            @(posedge clk); #1;
            check("m_valid", {63'd0, m_valid}, 64'd1);
            check("m_class", {63'd0, m_class}, {63'd0, ec});
            check("s_ready_result", {63'd0, s_ready}, 64'd0);
            for (int h = 0; h < hold; h++) begin
                s_valid = 1'b1;
                s_data  = 8'hEE;
                @(posedge clk); #1;
                check("hold_m_valid", {63'd0, m_valid}, 64'd1);
                check("hold_m_class", {63'd0, m_class}, {63'd0, ec});
                check("hold_s_ready", {63'd0, s_ready}, 64'd0);
                check("hold_feat_o", {24'd0, feat_o}, {24'd0, ef});
            end
            m_ready = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'b0;
            s_valid = 1'b0;
            check("m_valid_after_ack", {63'd0, m_valid}, 64'd0);
            check("s_ready_after_ack", {63'd0, s_ready}, 64'd1);
            check("feat_o_after_ack", {24'd0, feat_o}, {24'd0, ef});
        end else begin
            for (int h = 0; h < 3; h++) begin
                @(posedge clk); #1;
                check("err_no_m_valid", {63'd0, m_valid}, 64'd0);
                check("err_s_ready", {63'd0, s_ready}, 64'd1);
                check("err_pulse_width", {63'd0, frame_err}, 64'd0);
            end
        end
    endtask

    vec_t        tbl [8];
    frame_t      fr;
    logic [39:0] nf;
    logic        me, mc;
    int          len;
    logic [7:0]  bb [20];
    int          ptr, nres, last_cyc;
    logic        acc;
    logic [39:0] ef1;

    initial begin
        s_valid = 0; s_data = 0; s_last = 0; m_ready = 0;
        s_valid1 = 0; s_data1 = 0; s_last1 = 0; m_ready1 = 1;
        model_feat = '0;

        tbl[0] = '{b:'{8'h10,8'h80,8'h55,8'h20,8'hC0,8'h00,8'h00,8'h00}, len:5, feat:40'hC020558010, err:1'b0, cls:1'b0};
        tbl[1] = '{b:'{8'h40,8'h01,8'h02,8'h03,8'h04,8'h00,8'h00,8'h00}, len:5, feat:40'h0403020140, err:1'b0, cls:1'b1};
        tbl[2] = '{b:'{8'h11,8'h22,8'h33,8'h00,8'h00,8'h00,8'h00,8'h00}, len:3, feat:40'h0403332211, err:1'b1, cls:1'b0};
        tbl[3] = '{b:'{8'h10,8'h80,8'h55,8'h20,8'hC0,8'h00,8'h00,8'h00}, len:5, feat:40'hC020558010, err:1'b0, cls:1'b0};
        tbl[4] = '{b:'{8'hA1,8'hA2,8'hA3,8'hA4,8'hA5,8'hA6,8'hA7,8'h00}, len:7, feat:40'hA5A4A3A2A1, err:1'b1, cls:1'b0};
        tbl[5] = '{b:'{8'hFF,8'h00,8'hFF,8'h00,8'hFF,8'h00,8'h00,8'h00}, len:5, feat:40'hFF00FF00FF, err:1'b0, cls:1'b1};
        tbl[6] = '{b:'{8'h7F,8'hAA,8'hBB,8'hCC,8'hDD,8'h00,8'h00,8'h00}, len:5, feat:40'hDDCCBBAA7F, err:1'b0, cls:1'b1};
        tbl[7] = '{b:'{8'h77,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, len:1, feat:40'hDDCCBBAA77, err:1'b1, cls:1'b0};

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check("rst_feat_o", {24'd0, feat_o}, 64'd0);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_class", {63'd0, m_class}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_s_ready", {63'd0, s_ready}, 64'd1);

        // Table-driven frames
        for (int t = 0; t < 8; t++) begin
            run_frame(tbl[t].b, tbl[t].len, tbl[t].feat, tbl[t].err, tbl[t].cls, 0);
            model_feat = tbl[t].feat;
        end

        // Reset asserted during SETTLE discards the frame and the held result
        check("pre_rst_m_class", {63'd0, m_class}, 64'd1);
        fr = tbl[1].b;
        for (int i = 0; i < 5; i++) send_byte(fr[i], (i == 4));
        rst_n = 1'b0;
        #1;
        check("mid_rst_feat_o", {24'd0, feat_o}, 64'd0);
        check("mid_rst_m_class", {63'd0, m_class}, 64'd0);
        check("mid_rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("mid_rst_frame_err", {63'd0, frame_err}, 64'd0);
        check("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_release_s_ready", {63'd0, s_ready}, 64'd1);
        check("mid_rst_release_m_valid", {63'd0, m_valid}, 64'd0);
        model_feat = '0;
        fr = tbl[5].b;
        model_frame(model_feat, fr, 5, nf, me, mc);
        run_frame(fr, 5, nf, me, mc, 0);
        model_feat = nf;

        // Result held under back-pressure while a byte waits on the input
        fr = tbl[0].b;
        model_frame(model_feat, fr, 5, nf, me, mc);
        run_frame(fr, 5, nf, me, mc, 10);
        model_feat = nf;

        // Randomized frames against the frame-level model
        for (int t = 0; t < 30; t++) begin
            len = ($urandom_range(0, 9) < 6) ? 5 : int'($urandom_range(1, 8));
            for (int i = 0; i < 8; i++) fr[i] = 8'($urandom_range(0, 255));
            model_frame(model_feat, fr, len, nf, me, mc);
            run_frame(fr, len, nf, me, mc, int'($urandom_range(0, 3)));
            model_feat = nf;
        end

        // Back-to-back frames on the SETTLE_CYCLES=1 instance
        for (int i = 0; i < 20; i++) bb[i] = 8'($urandom_range(0, 255));
        ptr = 0; nres = 0; last_cyc = 0;
        s_valid1 = 1'b1; s_data1 = bb[0]; s_last1 = 1'b0;
        for (int c = 0; c < 120 && nres < 4; c++) begin
            @(negedge clk);
            acc = s_valid1 && s_ready1;
            if (m_valid1) begin
                ef1 = {bb[nres*5+4], bb[nres*5+3], bb[nres*5+2], bb[nres*5+1], bb[nres*5]};
                check("b2b_feat_o", {24'd0, feat_o1}, {24'd0, ef1});
                check("b2b_m_class", {63'd0, m_class1}, {63'd0, (bb[nres*5] >= 8'h40)});
                if (nres > 0) check("b2b_period", 64'(cyc - last_cyc), 64'd7);
                last_cyc = cyc;
                nres++;
            end
            @(posedge clk); #1;
            if (acc) begin
                ptr++;
                if (ptr < 20) begin
                    s_data1 = bb[ptr];
                    s_last1 = ((ptr % 5) == 4);
                end else begin
                    s_valid1 = 1'b0;
                    s_last1  = 1'b0;
                end
            end
        end
        s_valid1 = 1'b0;
        check("b2b_results", 64'(nres), 64'd4);
        check("b2b_frame_err", {63'd0, frame_err1}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
